// File: rtl/ledpanel_cmd_pkg.sv
// Shared constants and types for the LED panel command parser.
package ledpanel_cmd_pkg;
  localparam int PANEL_DIM = 32;
  localparam int COORD_W   = $clog2(PANEL_DIM);

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_SET_XY = 8'h01;
  localparam logic [7:0] OP_PIXELS = 8'h02;
  localparam logic [7:0] OP_FILL   = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARGS,
    ST_PIXEL,
    ST_FILL
  } state_t;
endpackage

// File: rtl/ledpanel_cmd_if.sv
// Byte-stream input and pixel-write output bundle of the panel command parser.
// Handshake: a byte moves on a rising edge where in_valid and in_ready are both
// high; the source holds in_data stable while in_valid is high and not accepted.
interface ledpanel_cmd_if;
  import ledpanel_cmd_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_data;
  logic               busy;
  logic               err;
  logic               wr_enable;
  logic [COORD_W-1:0] wr_addr_x;
  logic [COORD_W-1:0] wr_addr_y;
  logic [23:0]        wr_rgb_data;
  state_t             dbg_state;

  modport master (
    output in_valid, in_data,
    input  in_ready, busy, err, wr_enable, wr_addr_x, wr_addr_y, wr_rgb_data,
    input  dbg_state
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, busy, err, wr_enable, wr_addr_x, wr_addr_y, wr_rgb_data,
    output dbg_state
  );
endinterface

// File: rtl/ledpanel_cursor.sv
// Panel write cursor: load from SET_XY, advance after every streamed pixel.
module ledpanel_cursor
  import ledpanel_cmd_pkg::*;
#(
  parameter int AUTO_WRAP = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  input  logic               inc,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);
  localparam logic [COORD_W-1:0] MAX_C = COORD_W'(PANEL_DIM - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (load) begin
      x <= load_x;
      y <= load_y;
    end else if (inc) begin
      x <= x + COORD_W'(1);
      // Row advance only on column wrap; both wrap naturally at the panel edge.
      if (x == MAX_C && AUTO_WRAP != 0) y <= y + COORD_W'(1);
    end
  end
endmodule

// File: rtl/ledpanel_cmd.sv
// Command parser for a 32x32 LED panel: decodes NOP/SET_XY/PIXELS/FILL byte
// streams into registered frame-buffer pixel writes.
module ledpanel_cmd
  import ledpanel_cmd_pkg::*;
#(
  parameter int AUTO_WRAP = 1
) (
  input  logic           clk,
  input  logic           reset,
  ledpanel_cmd_if.slave  bus
);
  state_t             state, state_n;
  logic [2:0]         arg_idx, arg_idx_n;
  logic [7:0]         opcode, opcode_n;
  logic [8:0]         cnt, cnt_n;
  logic [1:0]         pix_idx, pix_idx_n;
  logic [7:0]         r_q, r_n, g_q, g_n;
  logic [COORD_W-1:0] x0, x0_n, y0, y0_n, wm1, wm1_n, hm1, hm1_n;
  logic [COORD_W-1:0] fi, fi_n, fj, fj_n;
  logic               wr_en_q, wr_en_n, err_q, err_n;
  logic [COORD_W-1:0] wr_x_q, wr_x_n, wr_y_q, wr_y_n;
  logic [23:0]        rgb_q, rgb_n;
  logic               cur_load, cur_inc, xfer;
  logic [COORD_W-1:0] cur_x, cur_y;

  ledpanel_cursor #(.AUTO_WRAP(AUTO_WRAP)) u_cursor (
    .clk    (clk),
    .reset  (reset),
    .load   (cur_load),
    .load_x (x0),
    .load_y (bus.in_data[COORD_W-1:0]),
    .inc    (cur_inc),
    .x      (cur_x),
    .y      (cur_y)
  );

  assign bus.in_ready    = !reset && (state != ST_FILL);
  assign xfer            = bus.in_valid && bus.in_ready;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.err         = err_q;
  assign bus.wr_enable   = wr_en_q;
  assign bus.wr_addr_x   = wr_x_q;
  assign bus.wr_addr_y   = wr_y_q;
  assign bus.wr_rgb_data = rgb_q;
  assign bus.dbg_state   = state;

  always_comb begin
    state_n = state;  arg_idx_n = arg_idx;  opcode_n = opcode;  cnt_n = cnt;
    pix_idx_n = pix_idx;  r_n = r_q;  g_n = g_q;
    x0_n = x0;  y0_n = y0;  wm1_n = wm1;  hm1_n = hm1;  fi_n = fi;  fj_n = fj;
    wr_en_n = 1'b0;  wr_x_n = wr_x_q;  wr_y_n = wr_y_q;  rgb_n = rgb_q;
    err_n = 1'b0;  cur_load = 1'b0;  cur_inc = 1'b0;
    case (state)
      ST_IDLE: if (xfer) begin
        opcode_n  = bus.in_data;
        arg_idx_n = 3'd0;
        case (bus.in_data)
          OP_NOP:                      ;
          OP_SET_XY, OP_PIXELS, OP_FILL: state_n = ST_ARGS;
          default:                     err_n = 1'b1;
        endcase
      end
      ST_ARGS: if (xfer) begin
        arg_idx_n = arg_idx + 3'd1;
        case (opcode)
          OP_SET_XY:
            if (arg_idx == 3'd0) x0_n = bus.in_data[COORD_W-1:0];
            else begin
              cur_load = 1'b1;
              state_n  = ST_IDLE;
            end
          OP_PIXELS: begin
            cnt_n     = (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
            pix_idx_n = 2'd0;
            state_n   = ST_PIXEL;
          end
          OP_FILL:
            case (arg_idx)
              3'd0: x0_n  = bus.in_data[COORD_W-1:0];
              3'd1: y0_n  = bus.in_data[COORD_W-1:0];
              3'd2: wm1_n = bus.in_data[COORD_W-1:0];
              3'd3: hm1_n = bus.in_data[COORD_W-1:0];
              3'd4: r_n   = bus.in_data;
              3'd5: g_n   = bus.in_data;
              default: begin
                // First fill write is issued directly off the B byte.
                wr_en_n = 1'b1;  wr_x_n = x0;  wr_y_n = y0;
                rgb_n   = {r_q, g_q, bus.in_data};
                fi_n    = '0;    fj_n   = '0;
                state_n = ST_FILL;
              end
            endcase
          default: state_n = ST_IDLE;
        endcase
      end
      ST_PIXEL: if (xfer) begin
        case (pix_idx)
          2'd0: begin r_n = bus.in_data;  pix_idx_n = 2'd1; end
          2'd1: begin g_n = bus.in_data;  pix_idx_n = 2'd2; end
          default: begin
            wr_en_n   = 1'b1;  wr_x_n = cur_x;  wr_y_n = cur_y;
            rgb_n     = {r_q, g_q, bus.in_data};
            cur_inc   = 1'b1;
            pix_idx_n = 2'd0;
            cnt_n     = cnt - 9'd1;
            if (cnt == 9'd1) state_n = ST_IDLE;
          end
        endcase
      end
      ST_FILL:
        if (fi == wm1 && fj == hm1) state_n = ST_IDLE;
        else begin
          wr_en_n = 1'b1;
          if (fi == wm1) begin
            fi_n = '0;  fj_n = fj + COORD_W'(1);
            wr_x_n = x0;  wr_y_n = y0 + fj + COORD_W'(1);
          end else begin
            fi_n = fi + COORD_W'(1);
            wr_x_n = x0 + fi + COORD_W'(1);  wr_y_n = y0 + fj;
          end
        end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;  arg_idx <= '0;  opcode <= '0;  cnt <= '0;  pix_idx <= '0;
      r_q <= '0;  g_q <= '0;  x0 <= '0;  y0 <= '0;  wm1 <= '0;  hm1 <= '0;
      fi <= '0;  fj <= '0;  wr_en_q <= 1'b0;  wr_x_q <= '0;  wr_y_q <= '0;
      rgb_q <= '0;  err_q <= 1'b0;
    end else begin
      state <= state_n;  arg_idx <= arg_idx_n;  opcode <= opcode_n;  cnt <= cnt_n;
      pix_idx <= pix_idx_n;  r_q <= r_n;  g_q <= g_n;  x0 <= x0_n;  y0 <= y0_n;
      wm1 <= wm1_n;  hm1 <= hm1_n;  fi <= fi_n;  fj <= fj_n;  wr_en_q <= wr_en_n;
      wr_x_q <= wr_x_n;  wr_y_q <= wr_y_n;  rgb_q <= rgb_n;  err_q <= err_n;
    end
  end
endmodule

// File: tb/tb_ledpanel_cmd.sv
// Directed bench for ledpanel_cmd; a wrapping and a non-wrapping instance see the same byte stream.
module tb_ledpanel_cmd;
  import ledpanel_cmd_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;
  int total = 0;
  int bad   = 0;

  ledpanel_cmd_if bus1();
  ledpanel_cmd_if bus0();
  assign bus1.in_valid = in_valid;
  assign bus1.in_data  = in_data;
  assign bus0.in_valid = in_valid;
  assign bus0.in_data  = in_data;

  ledpanel_cmd #(.AUTO_WRAP(1)) dut    (.clk(clk), .reset(reset), .bus(bus1));
  ledpanel_cmd #(.AUTO_WRAP(0)) dut_nw (.clk(clk), .reset(reset), .bus(bus0));

  // ---------------- write capture: {x, y, rgb} ----------------
  logic [33:0] got_q[$];
  logic [33:0] got0_q[$];
  logic [33:0] exp_q[$];
  logic [33:0] exp0_q[$];

  always @(negedge clk) begin
    if (bus1.wr_enable === 1'b1) got_q.push_back({bus1.wr_addr_x, bus1.wr_addr_y, bus1.wr_rgb_data});
    if (bus0.wr_enable === 1'b1) got0_q.push_back({bus0.wr_addr_x, bus0.wr_addr_y, bus0.wr_rgb_data});
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (bus1.in_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      total++; bad++;
      $display("FAIL send_timeout byte=%0h in_ready=%0b required=1", b, bus1.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #2;
    total++; if (bus1.in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b exp=0", bus1.in_ready); end
    total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", bus1.busy); end
    total++; if (bus1.wr_enable !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%0b exp=0", bus1.wr_enable); end
    total++; if ({bus1.wr_addr_x, bus1.wr_addr_y, bus1.wr_rgb_data} !== 34'h0) begin bad++;
      $display("FAIL rst_wr_regs got=%0h exp=0", {bus1.wr_addr_x, bus1.wr_addr_y, bus1.wr_rgb_data}); end
    total++; if (bus1.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", bus1.err); end
    total++; if (bus1.dbg_state !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", bus1.dbg_state, ST_IDLE); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus1.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%0b exp=1", bus1.in_ready); end
  endtask

  task automatic test_set_xy_pixels;
    got_q.delete();
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h1F);
    send_byte(8'h02);
    total++; if (bus1.busy !== 1'b1) begin bad++; $display("FAIL args_busy got=%0b exp=1", bus1.busy); end
    send_byte(8'h01); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    in_valid = 1'b0;
    total++; if (bus1.wr_enable !== 1'b1) begin bad++; $display("FAIL pix_latency got=%0b exp=1", bus1.wr_enable); end
    total++; if ({bus1.wr_addr_x, bus1.wr_addr_y, bus1.wr_rgb_data} !== {5'd5, 5'd31, 24'h112233}) begin bad++;
      $display("FAIL pix_write got=%0h exp=%0h", {bus1.wr_addr_x, bus1.wr_addr_y, bus1.wr_rgb_data}, {5'd5, 5'd31, 24'h112233}); end
    idle(2);
    total++; if (bus1.wr_enable !== 1'b0) begin bad++; $display("FAIL pix_one_cycle got=%0b exp=0", bus1.wr_enable); end
    total++; if (bus1.wr_rgb_data !== 24'h112233) begin bad++; $display("FAIL pix_hold got=%0h exp=112233", bus1.wr_rgb_data); end
    total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL pix_idle got=%0b exp=0", bus1.busy); end
    // Cursor should have moved to (6,31)
    send_byte(8'h02); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    idle(2);
    exp_q = '{{5'd5, 5'd31, 24'h112233}, {5'd6, 5'd31, 24'hAABBCC}};
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL pix_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad++;
        $display("FAIL pix_seq[%0d] got=%0h exp=%0h", i, (i < got_q.size()) ? got_q[i] : 34'h0, exp_q[i]); end
    end
  endtask

  task automatic test_wrap;
    got_q.delete(); got0_q.delete();
    send_byte(8'h01); send_byte(8'h1F); send_byte(8'h1F);
    send_byte(8'h02); send_byte(8'h02);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    send_byte(8'h40); send_byte(8'h50); send_byte(8'h60);
    send_byte(8'h00);  // opcode immediately after the last B byte
    idle(3);
    exp_q  = '{{5'd31, 5'd31, 24'h102030}, {5'd0, 5'd0,  24'h405060}};
    exp0_q = '{{5'd31, 5'd31, 24'h102030}, {5'd0, 5'd31, 24'h405060}};
    total++; if (got_q.size() != 2) begin bad++; $display("FAIL wrap_count got=%0d exp=2", got_q.size()); end
    total++; if (got0_q.size() != 2) begin bad++; $display("FAIL nowrap_count got=%0d exp=2", got0_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad++;
        $display("FAIL wrap_seq[%0d] got=%0h exp=%0h", i, (i < got_q.size()) ? got_q[i] : 34'h0, exp_q[i]); end
      total++;
      if (i >= got0_q.size() || got0_q[i] !== exp0_q[i]) begin bad++;
        $display("FAIL nowrap_seq[%0d] got=%0h exp=%0h", i, (i < got0_q.size()) ? got0_q[i] : 34'h0, exp0_q[i]); end
    end
    total++; if (bus1.busy !== 1'b0) begin bad++; $display("FAIL wrap_idle got=%0b exp=0", bus1.busy); end
  endtask

  task automatic test_fill;
    int low_cycles = 0;
    int guard = 0;
    got_q.delete(); got0_q.delete();
    send_byte(8'h03); send_byte(8'h1E); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'hFF); send_byte(8'h00); send_byte(8'h00);
    in_valid = 1'b0;
    total++; if (bus1.wr_enable !== 1'b1) begin bad++; $display("FAIL fill_latency got=%0b exp=1", bus1.wr_enable); end
    total++; if (bus1.dbg_state !== ST_FILL) begin bad++; $display("FAIL fill_state got=%0d exp=%0d", bus1.dbg_state, ST_FILL); end
    while (bus1.in_ready === 1'b0 && guard < 100) begin
      low_cycles++;
      @(negedge clk);
      guard++;
    end
    total++; if (low_cycles != 6) begin bad++; $display("FAIL fill_ready_low got=%0d exp=6", low_cycles); end
    exp_q = '{{5'd30, 5'd0, 24'hFF0000}, {5'd31, 5'd0, 24'hFF0000}, {5'd0, 5'd0, 24'hFF0000},
              {5'd30, 5'd1, 24'hFF0000}, {5'd31, 5'd1, 24'hFF0000}, {5'd0, 5'd1, 24'hFF0000}};
    total++; if (got_q.size() != 6) begin bad++; $display("FAIL fill_count got=%0d exp=6", got_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad++;
        $display("FAIL fill_seq[%0d] got=%0h exp=%0h", i, (i < got_q.size()) ? got_q[i] : 34'h0, exp_q[i]); end
    end
    total++; if (bus1.wr_enable !== 1'b0) begin bad++; $display("FAIL fill_end got=%0b exp=0", bus1.wr_enable); end
    // Cursor must be untouched by FILL: (1,0) wrapping, (1,31) non-wrapping
    got_q.delete(); got0_q.delete();
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    idle(2);
    total++; if (got_q.size() != 1 || got_q[0] !== {5'd1, 5'd0, 24'h010203}) begin bad++;
      $display("FAIL fill_cursor got=%0h exp=%0h", (got_q.size() > 0) ? got_q[0] : 34'h0, {5'd1, 5'd0, 24'h010203}); end
    total++; if (got0_q.size() != 1 || got0_q[0] !== {5'd1, 5'd31, 24'h010203}) begin bad++;
      $display("FAIL fill_cursor_nw got=%0h exp=%0h", (got0_q.size() > 0) ? got0_q[0] : 34'h0, {5'd1, 5'd31, 24'h010203}); end
  endtask

  task automatic test_handshake;
    logic [7:0] pix_bytes[5] = '{8'h02, 8'h01, 8'hAB, 8'hCD, 8'hEF};
    got_q.delete();
    send_byte(8'h01); send_byte(8'h0A); send_byte(8'h0C);
    foreach (pix_bytes[i]) begin
      send_byte(pix_bytes[i]);
      idle(1);
    end
    idle(2);
    total++; if (got_q.size() != 1 || got_q[0] !== {5'd10, 5'd12, 24'hABCDEF}) begin bad++;
      $display("FAIL stall_write got=%0h exp=%0h n=%0d", (got_q.size() > 0) ? got_q[0] : 34'h0, {5'd10, 5'd12, 24'hABCDEF}, got_q.size()); end
    got_q.delete();
    send_byte(8'h7A);
    in_valid = 1'b0;
    total++; if (bus1.err !== 1'b1) begin bad++; $display("FAIL err_pulse got=%0b exp=1", bus1.err); end
    @(negedge clk);
    total++; if (bus1.err !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%0b exp=0", bus1.err); end
    total++; if (got_q.size() != 0 || bus1.busy !== 1'b0) begin bad++;
      $display("FAIL err_side_effect writes=%0d busy=%0b exp writes=0 busy=0", got_q.size(), bus1.busy); end
  endtask

  task automatic test_reset_mid_fill;
    got_q.delete();
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h1F);
    send_byte(8'h1F); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if (bus1.wr_enable !== 1'b0) begin bad++; $display("FAIL abort_wr_en got=%0b exp=0", bus1.wr_enable); end
    total++; if (bus1.busy !== 1'b0 || bus1.in_ready !== 1'b0) begin bad++;
      $display("FAIL abort_status busy=%0b ready=%0b exp busy=0 ready=0", bus1.busy, bus1.in_ready); end
    total++; if (got_q.size() != 10 || got_q[9] !== {5'd9, 5'd0, 24'h010203}) begin bad++;
      $display("FAIL abort_prefix got=%0h n=%0d exp=%0h n=10", (got_q.size() > 9) ? got_q[9] : 34'h0, got_q.size(), {5'd9, 5'd0, 24'h010203}); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (got_q.size() != 10) begin bad++; $display("FAIL abort_no_more got=%0d exp=10", got_q.size()); end
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h77); send_byte(8'h88); send_byte(8'h99);
    idle(2);
    total++; if (got_q.size() != 11 || got_q[10] !== {5'd2, 5'd3, 24'h778899}) begin bad++;
      $display("FAIL post_abort_xy got=%0h exp=%0h", (got_q.size() > 10) ? got_q[10] : 34'h0, {5'd2, 5'd3, 24'h778899}); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_set_xy_pixels();
    test_wrap();
    test_fill();
    test_handshake();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
